// File: rtl/vend_txn_ctrl.sv
// rtl/vend_txn_ctrl.sv - checkout transaction sequencer: item/coin totals, confirm, servo vend, change
module vend_txn_ctrl #(
    parameter int unsigned SERVO_CYCLES   = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned PRICE0         = 3,
    parameter int unsigned PRICE1         = 5,
    parameter int unsigned PRICE2         = 8,
    parameter int unsigned PRICE3         = 10
) (
    input  logic       clock,
    input  logic       clr_n,
    input  logic       voice_valid,
    input  logic [1:0] voice_item,
    output logic       voice_ack,
    input  logic       ir_valid,
    input  logic [1:0] ir_item,
    output logic       ir_ack,
    input  logic       coin5_pulse,
    input  logic       coin1_pulse,
    input  logic       confirm_pulse,
    input  logic       cancel_pulse,
    output logic [3:0] item_sw,
    output logic [3:0] item_gw,
    output logic [3:0] pay_sw,
    output logic [3:0] pay_gw,
    output logic [3:0] chg_sw,
    output logic [3:0] chg_gw,
    output logic       en_duoji,
    output logic [2:0] state,
    output logic       insuf,
    output logic       ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOP = 2'd1;
    localparam logic [1:0] ST_VEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] SERVO_LAST = 32'(SERVO_CYCLES - 1);
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  TOTAL_MAX  = 8'd99;

    logic [1:0]  state_q, state_d;
    logic [6:0]  item_q, item_d;
    logic [6:0]  pay_q, pay_d;
    logic [6:0]  chg_q, chg_d;
    logic        chg_vld_q, chg_vld_d;
    logic        ovf_q, ovf_d;
    logic        insuf_q, insuf_d;
    logic        voice_ack_q, voice_ack_d;
    logic        ir_ack_q, ir_ack_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] servo_q, servo_d;

    logic        take_voice, take_ir, item_evt, coin_evt, any_evt;
    logic        shop_refund, shop_buy, shop_insuf, done_exit, servo_done;
    logic [6:0]  item_add, coin_add;
    logic [7:0]  item_sum, pay_sum;

    function automatic logic [6:0] price_of(input logic [1:0] code);
        case (code)
            2'd0:    price_of = 7'(PRICE0);
            2'd1:    price_of = 7'(PRICE1);
            2'd2:    price_of = 7'(PRICE2);
            default: price_of = 7'(PRICE3);
        endcase
    endfunction

    // Event decode: arbitration, coin sums and the per-state transition conditions
    always_comb begin
        logic accepting;
        logic block_adds;
        logic tmo_hit;
        logic confirm_ok;
        accepting   = (state_q == ST_IDLE) || (state_q == ST_SHOP);
        // A confirm or cancel in SHOP owns the cycle; held requests retry later.
        block_adds  = (state_q == ST_SHOP) && (cancel_pulse || confirm_pulse);
        take_voice  = accepting && !block_adds && voice_valid && !voice_ack_q;
        take_ir     = accepting && !block_adds && !take_voice && ir_valid && !ir_ack_q;
        item_evt    = take_voice || take_ir;
        coin_evt    = accepting && !block_adds && (coin5_pulse || coin1_pulse);
        any_evt     = item_evt || coin_evt;
        item_add    = take_voice ? price_of(voice_item) : price_of(ir_item);
        coin_add    = (coin5_pulse ? 7'd5 : 7'd0) + (coin1_pulse ? 7'd1 : 7'd0);
        item_sum    = {1'b0, item_q} + {1'b0, item_add};
        pay_sum     = {1'b0, pay_q} + {1'b0, coin_add};
        // >= so a rejected confirm landing on the last count still times out next cycle
        tmo_hit     = (tmo_q >= TMO_LAST);
        confirm_ok  = (item_q != 7'd0) && (pay_q >= item_q);
        shop_refund = (state_q == ST_SHOP) &&
                      (cancel_pulse || (tmo_hit && !any_evt && !confirm_pulse));
        shop_buy    = (state_q == ST_SHOP) && !cancel_pulse && confirm_pulse && confirm_ok;
        shop_insuf  = (state_q == ST_SHOP) && !cancel_pulse && confirm_pulse && !confirm_ok;
        done_exit   = (state_q == ST_DONE) && (cancel_pulse || tmo_hit);
        servo_done  = (state_q == ST_VEND) && (servo_q == SERVO_LAST);
    end

    // State register
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_evt)     state_d = ST_SHOP;
            ST_SHOP: if (shop_refund) state_d = ST_DONE;
                     else if (shop_buy) state_d = ST_VEND;
            ST_VEND: if (servo_done)  state_d = ST_DONE;
            default: if (done_exit)   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: totals, change, flags, acks and timers
    always_comb begin
        item_d      = item_q;
        pay_d       = pay_q;
        chg_d       = chg_q;
        chg_vld_d   = chg_vld_q;
        ovf_d       = ovf_q;
        insuf_d     = 1'b0;
        voice_ack_d = take_voice;
        ir_ack_d    = take_ir;

        if (item_evt) begin
            if (item_sum > TOTAL_MAX) ovf_d  = 1'b1;
            else                      item_d = item_sum[6:0];
        end
        if (coin_evt) begin
            if (pay_sum > TOTAL_MAX) ovf_d = 1'b1;
            else                     pay_d = pay_sum[6:0];
        end
        if (shop_buy) begin
            chg_d     = pay_q - item_q;
            chg_vld_d = 1'b1;
        end
        if (shop_insuf) begin
            insuf_d = 1'b1;
        end
        if (shop_refund) begin
            chg_d     = pay_q;
            chg_vld_d = 1'b1;
            item_d    = 7'd0;
        end
        if (done_exit) begin
            item_d    = 7'd0;
            pay_d     = 7'd0;
            chg_d     = 7'd0;
            chg_vld_d = 1'b0;
            ovf_d     = 1'b0;
        end

        if ((state_d != state_q) || any_evt)
            tmo_d = 32'd0;
        else if ((state_q == ST_SHOP) || (state_q == ST_DONE))
            tmo_d = tmo_q + 32'd1;
        else
            tmo_d = 32'd0;

        if ((state_q == ST_VEND) && (state_d == ST_VEND))
            servo_d = servo_q + 32'd1;
        else
            servo_d = 32'd0;
    end

    // Datapath registers
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            item_q      <= 7'd0;
            pay_q       <= 7'd0;
            chg_q       <= 7'd0;
            chg_vld_q   <= 1'b0;
            ovf_q       <= 1'b0;
            insuf_q     <= 1'b0;
            voice_ack_q <= 1'b0;
            ir_ack_q    <= 1'b0;
            tmo_q       <= 32'd0;
            servo_q     <= 32'd0;
        end else begin
            item_q      <= item_d;
            pay_q       <= pay_d;
            chg_q       <= chg_d;
            chg_vld_q   <= chg_vld_d;
            ovf_q       <= ovf_d;
            insuf_q     <= insuf_d;
            voice_ack_q <= voice_ack_d;
            ir_ack_q    <= ir_ack_d;
            tmo_q       <= tmo_d;
            servo_q     <= servo_d;
        end
    end

    // Outputs: state-derived servo enable, flags and BCD decode of the totals
    always_comb begin
        state     = {1'b0, state_q};
        en_duoji  = (state_q == ST_VEND);
        voice_ack = voice_ack_q;
        ir_ack    = ir_ack_q;
        insuf     = insuf_q;
        ovf       = ovf_q;
        item_sw   = 4'(item_q / 7'd10);
        item_gw   = 4'(item_q % 7'd10);
        pay_sw    = 4'(pay_q / 7'd10);
        pay_gw    = 4'(pay_q % 7'd10);
        if (chg_vld_q) begin
            chg_sw = 4'(chg_q / 7'd10);
            chg_gw = 4'(chg_q % 7'd10);
        end else begin
            chg_sw = 4'hF;
            chg_gw = 4'hF;
        end
    end

endmodule
